// File: rtl/riscv.sv
// -----------------------------------------------------------------------------
// riscv
// Definitions shared by the arithmetic issue queue: tag and uop widths, the
// arithmetic uop encoding, and the layout of one queue entry.
// No ports. This is a package imported with `import riscv::*;`.
// -----------------------------------------------------------------------------
package riscv;

  localparam int PTAG_W = 6;
  localparam int UOP_W  = 5;

  typedef enum logic [UOP_W-1:0] {
    UOP_ADD  = 5'd0,
    UOP_SUB  = 5'd1,
    UOP_AND  = 5'd2,
    UOP_OR   = 5'd3,
    UOP_XOR  = 5'd4,
    UOP_SLL  = 5'd5,
    UOP_SRL  = 5'd6,
    UOP_SRA  = 5'd7,
    UOP_SLT  = 5'd8,
    UOP_SLTU = 5'd9,
    UOP_LUI  = 5'd10,
    UOP_AUIPC = 5'd11
  } arith_uop_e;

  // The uop field is a plain vector so that any rename encoding is carried
  // through unchanged; arith_uop_e names the standard codes.
  typedef struct packed {
    logic              valid;
    logic [UOP_W-1:0]  uop;
    logic [PTAG_W-1:0] rd;
    logic [PTAG_W-1:0] rs1;
    logic              rs1_rdy;
    logic [PTAG_W-1:0] rs2;
    logic              rs2_rdy;
    logic              use_imm;
    logic [31:0]       imm;
  } iq_entry_t;

  // Physical tag 0 maps to x0, which never waits on a producer.
  function automatic logic is_zero_tag(input logic [PTAG_W-1:0] tag);
    return (tag == '0);
  endfunction

endpackage

// File: rtl/arith_issue_queue_if.sv
// -----------------------------------------------------------------------------
// arith_issue_queue_if
// Handshake bundle between rename, the arithmetic issue queue and the ALU.
// Signals:
//   enq_valid_i/enq_ready_o + enq_* payload : rename -> queue
//   iss_valid_o/iss_ready_i + iss_* payload : queue -> ALU
// Modports:
//   slave  : the issue queue (accepts enqueues, drives issue)
//   master : the environment (rename + ALU side)
// -----------------------------------------------------------------------------
interface arith_issue_queue_if;
  import riscv::*;

  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [UOP_W-1:0]  enq_uop_i;
  logic [PTAG_W-1:0] enq_rd_i;
  logic [PTAG_W-1:0] enq_rs1_i;
  logic              enq_rs1_rdy_i;
  logic [PTAG_W-1:0] enq_rs2_i;
  logic              enq_rs2_rdy_i;
  logic              enq_use_imm_i;
  logic [31:0]       enq_imm_i;

  logic              iss_valid_o;
  logic              iss_ready_i;
  logic [UOP_W-1:0]  iss_uop_o;
  logic [PTAG_W-1:0] iss_rd_o;
  logic [PTAG_W-1:0] iss_rs1_o;
  logic [PTAG_W-1:0] iss_rs2_o;
  logic              iss_use_imm_o;
  logic [31:0]       iss_imm_o;

  modport slave (
    input  enq_valid_i, enq_uop_i, enq_rd_i, enq_rs1_i, enq_rs1_rdy_i,
           enq_rs2_i, enq_rs2_rdy_i, enq_use_imm_i, enq_imm_i, iss_ready_i,
    output enq_ready_o, iss_valid_o, iss_uop_o, iss_rd_o, iss_rs1_o,
           iss_rs2_o, iss_use_imm_o, iss_imm_o
  );

  modport master (
    output enq_valid_i, enq_uop_i, enq_rd_i, enq_rs1_i, enq_rs1_rdy_i,
           enq_rs2_i, enq_rs2_rdy_i, enq_use_imm_i, enq_imm_i, iss_ready_i,
    input  enq_ready_o, iss_valid_o, iss_uop_o, iss_rd_o, iss_rs1_o,
           iss_rs2_o, iss_use_imm_o, iss_imm_o
  );

endinterface

// File: rtl/tag_wakeup_match.sv
// -----------------------------------------------------------------------------
// tag_wakeup_match
// Compares one physical tag against every writeback wakeup port.
// Ports:
//   tag_i    : tag to look up
//   wb_v_i   : valid per wakeup port
//   wb_tag_i : wakeup tags, port k at [k*PTAG_W +: PTAG_W]
//   hit_o    : some valid port carries tag_i
// Purely combinational.
// -----------------------------------------------------------------------------
module tag_wakeup_match
  import riscv::*;
#(
  parameter int NB_WB = 2
) (
  input  logic [PTAG_W-1:0]       tag_i,
  input  logic [NB_WB-1:0]        wb_v_i,
  input  logic [NB_WB*PTAG_W-1:0] wb_tag_i,
  output logic                    hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int k = 0; k < NB_WB; k++) begin
      if (wb_v_i[k] && (wb_tag_i[k*PTAG_W +: PTAG_W] == tag_i)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_issue_queue.sv
// -----------------------------------------------------------------------------
// arith_issue_queue
// In-order issue queue between rename and the arithmetic unit. Renamed uops
// are written into a circular buffer, writeback wakeups set their source-ready
// bits, and the head entry issues once both sources are ready.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : synchronous flush, empties the queue
//   iq            : arith_issue_queue_if.slave (enqueue and issue handshakes)
//   wb_v_i        : wakeup valid per writeback port
//   wb_tag_i      : wakeup tags, port k at [k*PTAG_W +: PTAG_W]
//   count_o       : occupied entries
//   perf_stall_cnt_o : cycles the head waited on operands (ARITH_IQ_PERF_EN)
// Build option: define ARITH_IQ_PERF_EN to add the stall counter.
// -----------------------------------------------------------------------------
module arith_issue_queue
  import riscv::*;
#(
  parameter int DEPTH = 8,
  parameter int NB_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  arith_issue_queue_if.slave      iq,
  input  logic [NB_WB-1:0]        wb_v_i,
  input  logic [NB_WB*PTAG_W-1:0] wb_tag_i,
  output logic [$clog2(DEPTH):0]  count_o
`ifdef ARITH_IQ_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  iq_entry_t        mem [DEPTH];
  ptr_t             head;
  ptr_t             tail;
  logic [AW-1:0]    head_idx;
  logic [AW-1:0]    tail_idx;
  logic             full;
  logic             enq_fire;
  logic             iss_fire;
  iq_entry_t        head_entry;
  logic             head_rdy;
  iq_entry_t        enq_entry;
  logic [DEPTH-1:0] rs1_hit;
  logic [DEPTH-1:0] rs2_hit;
  logic             enq_rs1_hit;
  logic             enq_rs2_hit;

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];

  // Same index with opposite wrap bits means the tail has lapped the head.
  assign full    = (head_idx == tail_idx) && (head[AW] != tail[AW]);
  assign count_o = tail - head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_match
    tag_wakeup_match #(.NB_WB(NB_WB)) u_rs1_match (
      .tag_i    (mem[i].rs1),
      .wb_v_i   (wb_v_i),
      .wb_tag_i (wb_tag_i),
      .hit_o    (rs1_hit[i])
    );
    tag_wakeup_match #(.NB_WB(NB_WB)) u_rs2_match (
      .tag_i    (mem[i].rs2),
      .wb_v_i   (wb_v_i),
      .wb_tag_i (wb_tag_i),
      .hit_o    (rs2_hit[i])
    );
  end

  // A producer writing back in the same cycle as the enqueue must not be
  // missed, so the incoming sources are matched against the buses too.
  tag_wakeup_match #(.NB_WB(NB_WB)) u_enq_rs1_match (
    .tag_i    (iq.enq_rs1_i),
    .wb_v_i   (wb_v_i),
    .wb_tag_i (wb_tag_i),
    .hit_o    (enq_rs1_hit)
  );
  tag_wakeup_match #(.NB_WB(NB_WB)) u_enq_rs2_match (
    .tag_i    (iq.enq_rs2_i),
    .wb_v_i   (wb_v_i),
    .wb_tag_i (wb_tag_i),
    .hit_o    (enq_rs2_hit)
  );

  always_comb begin
    enq_entry         = '0;
    enq_entry.valid   = 1'b1;
    enq_entry.uop     = iq.enq_uop_i;
    enq_entry.rd      = iq.enq_rd_i;
    enq_entry.rs1     = iq.enq_rs1_i;
    enq_entry.rs1_rdy = iq.enq_rs1_rdy_i | enq_rs1_hit | is_zero_tag(iq.enq_rs1_i);
    enq_entry.rs2     = iq.enq_rs2_i;
    enq_entry.rs2_rdy = iq.enq_rs2_rdy_i | enq_rs2_hit | is_zero_tag(iq.enq_rs2_i)
                      | iq.enq_use_imm_i;
    enq_entry.use_imm = iq.enq_use_imm_i;
    enq_entry.imm     = iq.enq_imm_i;
  end

  // Readiness uses stored bits only; a wakeup seen this cycle counts next cycle.
  assign head_entry     = mem[head_idx];
  assign head_rdy       = head_entry.rs1_rdy & head_entry.rs2_rdy;
  assign iq.iss_valid_o = head_entry.valid & head_rdy;
  assign iq.enq_ready_o = ~full;

  assign enq_fire = iq.enq_valid_i & ~full & ~flush_i;
  assign iss_fire = iq.iss_valid_o & iq.iss_ready_i & ~flush_i;

  // Payload is forced to zero when the head slot is empty so stale data from
  // already-issued entries never appears on the bus.
  always_comb begin
    iq.iss_uop_o     = '0;
    iq.iss_rd_o      = '0;
    iq.iss_rs1_o     = '0;
    iq.iss_rs2_o     = '0;
    iq.iss_use_imm_o = 1'b0;
    iq.iss_imm_o     = '0;
    if (head_entry.valid) begin
      iq.iss_uop_o     = head_entry.uop;
      iq.iss_rd_o      = head_entry.rd;
      iq.iss_rs1_o     = head_entry.rs1;
      iq.iss_rs2_o     = head_entry.rs2;
      iq.iss_use_imm_o = head_entry.use_imm;
      iq.iss_imm_o     = head_entry.imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      head <= '0;
      tail <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
      end
      head <= '0;
      tail <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem[i].valid) begin
          if (rs1_hit[i]) mem[i].rs1_rdy <= 1'b1;
          if (rs2_hit[i]) mem[i].rs2_rdy <= 1'b1;
        end
      end
      if (iss_fire) begin
        mem[head_idx].valid <= 1'b0;
        head                <= head + ptr_t'(1);
      end
      // Never the same slot as the issue: issue needs a non-empty queue and
      // enqueue a non-full one, so tail differs from head whenever both fire.
      if (enq_fire) begin
        mem[tail_idx] <= enq_entry;
        tail          <= tail + ptr_t'(1);
      end
    end
  end

`ifdef ARITH_IQ_PERF_EN
  // Counts operand stalls of the head; survives flushes and saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt_o <= '0;
    end else if (head_entry.valid && !head_rdy && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/arith_issue_queue.md
Name: arith_issue_queue

Overview:
- In-order issue queue for the arithmetic execution unit, directly downstream of the rename stage.
- Rename writes renamed arithmetic uops (physical tags, source-ready bits, immediate) into a circular buffer.
- Wakeup tags from the writeback buses set source-ready bits.
- The head entry issues to the ALU once both sources are ready. One enqueue and one issue per cycle maximum.

Parameters:
DEPTH, 8, number of entries (power of two, >=2)
PTAG_W, 6, physical register tag width (64 PRF entries)
UOP_W, 5, arithmetic micro-op encoding width
NB_WB, 2, number of writeback wakeup ports

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
flush_i  input  1  pipeline flush (mispredict/exception)
enq_valid_i  input  1  rename presents a uop
enq_ready_o  output  1  queue can accept a uop
enq_uop_i  input  UOP_W  micro-op
enq_rd_i  input  PTAG_W  destination physical tag
enq_rs1_i  input  PTAG_W  source 1 physical tag
enq_rs1_rdy_i  input  1  source 1 ready at rename
enq_rs2_i  input  PTAG_W  source 2 physical tag
enq_rs2_rdy_i  input  1  source 2 ready at rename
enq_use_imm_i  input  1  source 2 replaced by immediate
enq_imm_i  input  32  immediate
wb_v_i  input  NB_WB  wakeup valid per port
wb_tag_i  input  NB_WB*PTAG_W  wakeup tags, port k at [k*PTAG_W +: PTAG_W]
iss_valid_o  output  1  head uop issuable
iss_ready_i  input  1  ALU accepts
iss_uop_o  output  UOP_W  issued micro-op
iss_rd_o  output  PTAG_W  issued destination tag
iss_rs1_o  output  PTAG_W  issued source 1 tag
iss_rs2_o  output  PTAG_W  issued source 2 tag
iss_use_imm_o  output  1  immediate select
iss_imm_o  output  32  immediate
count_o  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, `rst`=1):
  - All entries invalid; head and tail pointers 0.
  - `count_o`=0, `enq_ready_o`=1, `iss_valid_o`=0, all `iss_*` data outputs 0.
- Pointers: head/tail are $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - full when indices are equal and MSBs differ.
  - empty when pointers are equal.
  - Indices wrap from DEPTH-1 to 0, toggling the MSB.
- Enqueue:
  - `enq_ready_o` = !full, purely registered-state based, with no credit for a same-cycle issue.
  - Enqueue fires when `enq_valid_i && enq_ready_o`; the entry is written at tail and tail increments.
- Ready bits: source ready is stored as `enq_rsX_rdy_i`, OR any same-cycle `wb_v_i[k]` with a tag match, OR tag==0 (x0 is always ready).
  - With `use_imm`, rs2 is stored ready regardless of its tag.
- Wakeup: each cycle, every valid entry whose rs1/rs2 tag matches any valid wakeup port sets that ready bit. Bits never clear while an entry is valid.
- Issue:
  - `iss_valid_o` = head valid && rs1_rdy && rs2_rdy, using registered bits only; same-cycle wakeup takes effect next cycle.
  - `iss_*` data outputs are combinational from the head entry.
  - Issue fires on `iss_valid_o && iss_ready_i`: head invalidated, head increments.
  - Younger ready entries never bypass a blocked head.
- Latency: minimum enqueue-to-issue is 1 cycle; a uop written in cycle N is visible at the head in N+1.
- Simultaneous enqueue and issue: both performed and count unchanged. When empty, the enqueued entry cannot issue the same cycle.
- `flush_i`: synchronous, highest priority.
  - All entries invalidated, pointers reset to 0.
  - Same-cycle enqueue and issue are dropped; `iss_valid_o` is still driven combinationally that cycle, and the consumer ignores it under flush.
- `count_o` = tail - head (pointer subtraction, width $clog2(DEPTH)+1).
- While `iss_valid_o`=1 and `iss_ready_i`=0, head outputs stay stable.

Optional Feature:
- Macro `ARITH_IQ_PERF_EN`.
- Defined: adds output `perf_stall_cnt_o` (32 bits, reset 0). It increments, saturating at 0xFFFFFFFF, each cycle the head is valid but not ready. Flush does not clear it.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package `riscv`:
  - PTAG_W and UOP_W localparams.
  - Arithmetic uop enum.
  - `iq_entry_t` packed struct {valid, uop, rd, rs1, rs1_rdy, rs2, rs2_rdy, use_imm, imm}.
- Sub-module `tag_wakeup_match`: combinational compare of one tag against NB_WB wakeup ports, returning a hit. Instantiated 2*DEPTH+2 times (entries plus the enqueue path).

Test Plan:
- Reset then enqueue uop rd=5, rs1=0, rs2=3 with rs2_rdy=1 -> `iss_valid_o`=1 next cycle, `iss_rd_o`=5, `count_o`=1.
- Enqueue rs1=7 not ready; three cycles later pulse wb_v_i[1] with tag 7 -> `iss_valid_o` rises the following cycle, not before.
- Enqueue with rs2=9 not ready while wb tag 9 is valid the same cycle -> stored ready, issues next cycle.
- Fill 8 entries with `iss_ready_i`=0 -> `enq_ready_o`=0, `count_o`=8. Then one enqueue+issue per cycle for 20 cycles -> order preserved across pointer wrap.
- Head blocked on tag 12 while entry 2 is ready -> no issue until tag 12 wakes up; the head issues first.
- Queue at 5 entries, assert `flush_i` with `enq_valid_i`=1 -> next cycle `count_o`=0, `iss_valid_o`=0, the enqueued uop is lost.
